// File: rtl/pxs_vga_sync_gen.sv
// pxs_vga_sync_gen: free-running VGA timing generator at the head of the iPxs
// pixel-stream chain. It emits coordinates, HSync, VSync and ActiveVideo (no RGB).
// Latency: 1 px_clk from counter state to registered outputs. Backpressure: none.
// The block never stalls on downstream. px_en=0 freezes the counters and all outputs.
//
// Ports:
//   px_clk    in   1   pixel clock
//   rst_n     in   1   asynchronous active-low reset
//   px_en     in   1   advance enable; when low, counters and outputs hold
//   VGAStr_o  out  23  {X[22:13], Y[12:3], HSync[2], VSync[1], ActiveVideo[0]}
//   frame_o   out  1   pulse on the beat carrying (X=0, Y=0)
//   line_o    out  1   pulse on every beat carrying X=0
module pxs_vga_sync_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_ACT = 1'b0
) (
  input  logic        px_clk,
  input  logic        rst_n,
  input  logic        px_en,
  output logic [22:0] VGAStr_o,
  output logic        frame_o,
  output logic        line_o
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Counters are 10 bits wide, so a line or frame longer than 1024 cannot be represented.
  if (H_TOTAL > 1024 || H_TOTAL == 0) begin : g_bad_h_total
    $error("pxs_vga_sync_gen: H_TOTAL must be in 1..1024");
  end
  if (V_TOTAL > 1024 || V_TOTAL == 0) begin : g_bad_v_total
    $error("pxs_vga_sync_gen: V_TOTAL must be in 1..1024");
  end

  // Comparisons are done at 11 bits. A threshold of exactly 1024 stays representable.
  localparam logic [10:0] H_LAST_C       = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST_C       = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACTIVE_C     = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACTIVE_C     = 11'(V_ACTIVE);
  localparam logic [10:0] H_SYNC_START_C = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END_C   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_SYNC_START_C = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END_C   = 11'(V_ACTIVE + V_FP + V_SYNC);

  // Counter state
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic [9:0] h_nxt;
  logic [9:0] v_nxt;
  logic [10:0] h_ext;
  logic [10:0] v_ext;
  logic        h_wrap;
  logic        v_wrap;

  // Decoded (pre-register) stream fields
  logic        active_d;
  logic        hsync_d;
  logic        vsync_d;
  logic        line_d;
  logic        frame_d;

  // Registered outputs
  logic [9:0]  x_q;
  logic [9:0]  y_q;
  logic        active_q;
  logic        hsync_q;
  logic        vsync_q;
  logic        frame_q;
  logic        line_q;

  assign h_ext  = {1'b0, h_cnt};
  assign v_ext  = {1'b0, v_cnt};
  assign h_wrap = (h_ext == H_LAST_C);
  assign v_wrap = (v_ext == V_LAST_C);

  // The vertical counter only moves when the horizontal counter wraps.
  // (H_TOTAL-1, V_TOTAL-1) therefore rolls over to (0,0) in one step.
  always_comb begin
    h_nxt = h_cnt + 10'd1;
    v_nxt = v_cnt;
    if (h_wrap) begin
      h_nxt = '0;
      v_nxt = v_wrap ? '0 : (v_cnt + 10'd1);
    end
  end

  // The decode uses the pre-increment counts. Each registered beat therefore
  // describes the position the counters held before the enabled edge.
  always_comb begin
    active_d = (h_ext < H_ACTIVE_C) && (v_ext < V_ACTIVE_C);
    hsync_d  = ((h_ext >= H_SYNC_START_C) && (h_ext < H_SYNC_END_C)) ? SYNC_ACT : ~SYNC_ACT;
    vsync_d  = ((v_ext >= V_SYNC_START_C) && (v_ext < V_SYNC_END_C)) ? SYNC_ACT : ~SYNC_ACT;
    line_d   = (h_cnt == 10'd0);
    frame_d  = (h_cnt == 10'd0) && (v_cnt == 10'd0);
  end

  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      active_q <= 1'b0;
      hsync_q  <= ~SYNC_ACT;
      vsync_q  <= ~SYNC_ACT;
      frame_q  <= 1'b0;
      line_q   <= 1'b0;
    end else if (px_en) begin
      h_cnt    <= h_nxt;
      v_cnt    <= v_nxt;
      x_q      <= h_cnt;
      y_q      <= v_cnt;
      active_q <= active_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      frame_q  <= frame_d;
      line_q   <= line_d;
    end
  end

  assign VGAStr_o = {x_q, y_q, hsync_q, vsync_q, active_q};
  assign frame_o  = frame_q;
  assign line_o   = line_q;

endmodule

// File: doc/pxs_vga_sync_gen.md
Name: pxs_vga_sync_gen

Overview:
- Head of the iPxs pixel-stream chain.
- Free-running horizontal/vertical counters produce the 23-bit VGA stream: coordinates, sync and ActiveVideo, no RGB.
- The output feeds the constant-colour/RGB stages directly and uses the shared stream layout: bit0 ActiveVideo, bit1 VSync, bit2 HSync, bits12:3 YCoord, bits22:13 XCoord.
- Default timing is 640x480@60 progressive (800x525 total).

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (px)
- H_SYNC, 96, HSync pulse width (px)
- H_BP, 48, horizontal back porch (px)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, VSync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_ACT, 0, level of HSync/VSync while asserted (0 = active-low)

Ports:
- px_clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- px_en  in  1  advance enable; when low, counters and outputs hold
- VGAStr_o  out  23  pixel stream (layout above), registered
- frame_o  out  1  one-cycle pulse, registered, coincident with the stream beat for (X=0,Y=0)
- line_o  out  1  one-cycle pulse, registered, coincident with every beat where X=0

Behaviour:
- Clock and reset:
  - One clock, px_clk.
  - rst_n is asynchronous active-low: assertion takes effect immediately; release is sampled on posedge px_clk.
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
  - Both must be ≤1024 (10-bit counters); this is checked by elaboration-time assertion.
- Counters:
  - 10-bit h_cnt and v_cnt, both reset to 0.
  - On posedge with px_en=1: h_cnt increments; at H_TOTAL-1 it wraps to 0.
  - v_cnt increments only when h_cnt wraps; at V_TOTAL-1 it wraps to 0 on that same edge.
  - Result: (H_TOTAL-1, V_TOTAL-1) is followed by (0,0).
- Decode, registered on the same enabled edge using the pre-increment counter values (1-cycle latency):
  - XCoord = h_cnt; YCoord = v_cnt. Coordinates are valid through blanking, range 0..H_TOTAL-1 / 0..V_TOTAL-1.
  - ActiveVideo = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - HSync = SYNC_ACT when H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751), otherwise ~SYNC_ACT.
  - VSync = SYNC_ACT when V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491), otherwise ~SYNC_ACT. VSync is line-based and is not aligned to HSync edges.
  - line_o = (h_cnt == 0); frame_o = (h_cnt == 0 && v_cnt == 0).
- px_en=0:
  - Counters and all outputs hold their values.
  - frame_o/line_o also hold. Consumers qualify them with px_en.
- Reset values:
  - VGAStr_o: X=0, Y=0, ActiveVideo=0, HSync=VSync=~SYNC_ACT.
  - frame_o=0, line_o=0.
  - The first enabled edge after release emits (0,0) with ActiveVideo=1, frame_o=1, line_o=1.
- Reset mid-frame: outputs go to reset values asynchronously and counters restart at (0,0). No partial-frame recovery.
- Sequencing:
  - No handshake.
  - Downstream stages register the stream once per px_clk and add their own latency.
  - This block never stalls on downstream.

Test Plan:
- Reset, then px_en=1 → check the idle values while rst_n=0 (X=0, Y=0, A=0, HS=VS=1). On the 1st enabled edge, VGAStr_o shows X=0, Y=0, A=1, HS=1, VS=1, frame_o=1, line_o=1.
- Run one line → A=1 for X 0..639, 0 for X 640..799. HS=0 exactly for X 656..751 (96 beats). line_o period is 800 beats.
- Run a full frame (420000 beats) → VS=0 for Y 490..491 (1600 beats). frame_o fires once every 420000 beats. The beat after (799,524) is (0,0).
- Toggle px_en low for 5 cycles at X=300 → VGAStr_o is frozen at X=300 for those cycles, then resumes at X=301. Line length is unchanged in enabled beats.
- Assert rst_n low asynchronously at (400,200) → outputs take reset values before the next edge. After release, the sequence restarts at (0,0).
- Override SYNC_ACT=1 → HS/VS idle 0 and pulse 1 over the same windows.
